// File: rtl/serial_pkg.sv
// Shared constants and types for the serial pattern source and sequence detectors.
package serial_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_RPT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } state_t;

  // Detector state constants shared by the serial sequence detectors
  localparam logic [1:0] DET_S0 = 2'd0;
  localparam logic [1:0] DET_S1 = 2'd1;
  localparam logic [1:0] DET_S2 = 2'd2;
  localparam logic [1:0] DET_S3 = 2'd3;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register; dout is bit len-1 of the current contents.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [LEN_W-1:0] len,
  output logic             dout
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end
  end

  assign dout = |(sr_q & (WIDTH'(1) << (len - LEN_W'(1))));

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: MSB-first bursts of programmable length,
// repeated rpt+1 times with a one-cycle gap between repetitions.
module serial_pattern_gen
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LEN_W = $clog2(WIDTH) + 1,
  parameter int unsigned RPT_W = DEF_RPT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [RPT_W-1:0] rpt,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] pattern_q, pattern_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] cnt_q, cnt_n;
  logic [RPT_W-1:0] rpt_q, rpt_n;
  logic             x_n, valid_n, busy_n, done_n;
  logic             load, shift, sr_bit;
  logic [WIDTH-1:0] din;
  logic [LEN_W-1:0] len_eff;

  // Shift register holds the pattern pre-shifted by one so its output is the next bit to send
  piso_shift_reg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_piso (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (din),
    .len     (len_q),
    .dout    (sr_bit)
  );

  assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

  always_comb begin
    state_n   = state_q;
    pattern_n = pattern_q;
    len_n     = len_q;
    cnt_n     = cnt_q;
    rpt_n     = rpt_q;
    x_n       = 1'b0;
    valid_n   = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    din       = pattern_q << 1;
    case (state_q)
      IDLE: begin
        if (start && (len_eff != '0)) begin
          state_n   = SHIFT;
          pattern_n = pattern;
          len_n     = len_eff;
          rpt_n     = rpt;
          cnt_n     = len_eff - LEN_W'(1);
          load      = 1'b1;
          din       = pattern << 1;
          x_n       = |(pattern & (WIDTH'(1) << (len_eff - LEN_W'(1))));
          valid_n   = 1'b1;
          busy_n    = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_n   = cnt_q - LEN_W'(1);
          shift   = 1'b1;
          x_n     = sr_bit;
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end else if (rpt_q != '0) begin
          rpt_n   = rpt_q - RPT_W'(1);
          state_n = GAP;
          busy_n  = 1'b1;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        state_n = SHIFT;
        cnt_n   = len_q - LEN_W'(1);
        load    = 1'b1;
        x_n     = |(pattern_q & (WIDTH'(1) << (len_q - LEN_W'(1))));
        valid_n = 1'b1;
        busy_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rpt_q     <= '0;
      x         <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      pattern_q <= pattern_n;
      len_q     <= len_n;
      cnt_q     <= cnt_n;
      rpt_q     <= rpt_n;
      x         <= x_n;
      valid     <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed and randomized bursts checked cycle-by-cycle against a queue-based reference model.
module tb_serial_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] rpt;
  logic       x, valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_pattern_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .rpt     (rpt),
    .x       (x),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".x"}, 32'(x), 0);
    chk({tag, ".valid"}, 32'(valid), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  // Expected {valid,x} for every busy cycle of one burst
  task automatic build_model(input logic [7:0] pat, input int l, input int r,
                             output logic [1:0] q[$]);
    int le;
    le = (l > 8) ? 8 : l;
    q = {};
    for (int rep = 0; rep <= r; rep++) begin
      for (int k = le - 1; k >= 0; k--) q.push_back({1'b1, pat[k]});
      if (rep < r) q.push_back(2'b00);
    end
  endtask

  // Issue one start, scramble inputs during the burst, check every cycle and the done pulse
  task automatic run_burst(input string tag, input logic [7:0] pat, input logic [3:0] l,
                           input logic [3:0] r);
    logic [1:0] q[$];
    build_model(pat, int'(l), int'(r), q);
    @(negedge clk);
    pattern = pat; len = l; rpt = r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    foreach (q[i]) begin
      @(negedge clk);
      chk({tag, ".valid"}, 32'(valid), 32'(q[i][1]));
      chk({tag, ".x"}, 32'(x), 32'(q[i][0]));
      chk({tag, ".busy"}, 32'(busy), 1);
      chk({tag, ".done"}, 32'(done), 0);
      pattern = 8'($urandom); len = 4'($urandom); rpt = 4'($urandom);
    end
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 1);
    chk({tag, ".busy_end"}, 32'(busy), 0);
    chk({tag, ".valid_end"}, 32'(valid), 0);
    @(negedge clk);
    chk({tag, ".done_fall"}, 32'(done), 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pattern = '0; len = '0; rpt = '0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    run_burst("basic111", 8'h07, 4'd3, 4'd0);
    run_burst("a5_rpt2", 8'hA5, 4'd8, 4'd2);

    // len=0 start is ignored
    @(negedge clk);
    pattern = 8'hFF; len = 4'd0; rpt = 4'd1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("len0");
    end
    start = 1'b0;

    run_burst("len15", 8'h96, 4'd15, 4'd0);

    // Input isolation with start held high: back-to-back second burst from 8'hFF
    @(negedge clk);
    pattern = 8'h03; len = 4'd2; rpt = 4'd0; start = 1'b1;
    @(negedge clk);
    chk("iso.b0", {30'd0, valid, x}, 32'h3);
    pattern = 8'hFF;
    @(negedge clk);
    chk("iso.b1", {30'd0, valid, x}, 32'h3);
    @(negedge clk);
    chk("iso.done", {30'd0, busy, done}, 32'h1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("iso2.b0", {29'd0, busy, valid, x}, 32'h7);
    @(negedge clk);
    chk("iso2.b1", {29'd0, busy, valid, x}, 32'h7);
    @(negedge clk);
    chk("iso2.done", {30'd0, busy, done}, 32'h1);

    // Reset abort during the 4th bit
    @(negedge clk);
    pattern = 8'hFF; len = 4'd8; rpt = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort.bit", {29'd0, busy, valid, x}, 32'h7);
    end
    reset_n = 1'b0;
    #1;
    chk_idle("abort.now");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle("abort.after");
    end
    run_burst("after_abort", 8'h5C, 4'd6, 4'd1);

    run_burst("max_rpt", 8'h01, 4'd1, 4'hF);

    for (int t = 0; t < 20; t++) begin
      logic [3:0] rl;
      rl = 4'($urandom_range(15, 1));
      run_burst("rand", 8'($urandom), rl, 4'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
